// File: rtl/fifo_bridge_xfer.sv
// Moves one word at a time from FIFO A to FIFO B through a selectable transform,
// with a saturating transfer counter. Optional parity outputs: FIFO_BRIDGE_PARITY_EN.
module fifo_bridge_xfer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] FIFOA_OUT,
    input  logic              FIFOA_empty,
    output logic              FIFOA_ren,
    input  logic              FIFOB_full,
    output logic [DATA_W-1:0] FIFOB_IN,
    output logic              FIFOB_wen,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              clr,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_count,
`ifdef FIFO_BRIDGE_PARITY_EN
    output logic              FIFOB_par,
    output logic [7:0]        par_err_cnt,
`endif
    output logic              Triggered
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned LAT_W  = 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] xform_c;
    logic              capture_c;
    logic              wen_set_c;

    // Data transform applied to the word as it is captured
    always_comb begin
        xform_c = FIFOA_OUT;
        case (mode)
            2'b01: xform_c = ~FIFOA_OUT;
            2'b10: begin
                for (int k = 0; k < int'(NBYTES); k++) begin
                    xform_c[8*(int'(NBYTES)-1-k) +: 8] = FIFOA_OUT[8*k +: 8];
                end
            end
            default: xform_c = FIFOA_OUT;
        endcase
    end

    // A write is armed at the capture edge or at the first unstalled edge in WRITE
    assign capture_c = (state == WAIT) && (lat_cnt == '0);
    assign wen_set_c = !FIFOB_full &&
                       (capture_c || ((state == WRITE) && !FIFOB_wen));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            FIFOA_ren <= 1'b0;
            FIFOB_wen <= 1'b0;
            FIFOB_IN  <= '0;
            busy      <= 1'b0;
        end else begin
            FIFOA_ren <= 1'b0;
            FIFOB_wen <= wen_set_c;
            case (state)
                IDLE: begin
                    if (enable && !FIFOA_empty && !FIFOB_full) begin
                        state     <= REQ;
                        FIFOA_ren <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                REQ: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (capture_c) begin
                        state    <= WRITE;
                        FIFOB_IN <= xform_c;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (FIFOB_wen) begin
                        state    <= IDLE;
                        FIFOB_IN <= '0;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host-visible counter and sticky flag; clr overrides a coincident write
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
            Triggered  <= 1'b0;
        end else if (clr) begin
            xfer_count <= '0;
            Triggered  <= 1'b0;
        end else if (wen_set_c) begin
            Triggered <= 1'b1;
            if (xfer_count != '1) xfer_count <= xfer_count + 1'b1;
        end
    end

`ifdef FIFO_BRIDGE_PARITY_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            FIFOB_par   <= 1'b0;
            par_err_cnt <= '0;
        end else begin
            if (capture_c) begin
                FIFOB_par <= ^xform_c;
                if (^FIFOA_OUT && par_err_cnt != '1) par_err_cnt <= par_err_cnt + 1'b1;
            end else if (state == WRITE && FIFOB_wen) begin
                FIFOB_par <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_bridge_xfer.sv
// Directed bench: dut_a uses RD_LAT=1/CNT_W=4, dut_b uses RD_LAT=3/CNT_W=16.
module tb_fifo_bridge_xfer;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_out, b_out, a_in, b_in;
    logic        a_empty, b_empty, a_ren, b_ren, a_wen, b_wen, a_busy, b_busy, a_trig, b_trig;
    logic        a_full = 1'b0, b_full = 1'b0, a_en = 1'b0, b_en = 1'b0, a_clr = 1'b0, b_clr = 1'b0;
    logic [1:0]  a_mode = 2'd0, b_mode = 2'd0;
    logic [3:0]  a_cnt;
    logic [15:0] b_cnt;
`ifdef FIFO_BRIDGE_PARITY_EN
    logic        a_par, b_par;
    logic [7:0]  a_perr, b_perr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    fifo_bridge_xfer #(.DATA_W(32), .RD_LAT(1), .CNT_W(4)) dut_a (
        .CLK(CLK), .rst_n(rst_n), .FIFOA_OUT(a_out), .FIFOA_empty(a_empty), .FIFOA_ren(a_ren),
        .FIFOB_full(a_full), .FIFOB_IN(a_in), .FIFOB_wen(a_wen), .enable(a_en), .mode(a_mode),
        .clr(a_clr), .busy(a_busy), .xfer_count(a_cnt),
`ifdef FIFO_BRIDGE_PARITY_EN
        .FIFOB_par(a_par), .par_err_cnt(a_perr),
`endif
        .Triggered(a_trig));

    fifo_bridge_xfer #(.DATA_W(32), .RD_LAT(3), .CNT_W(16)) dut_b (
        .CLK(CLK), .rst_n(rst_n), .FIFOA_OUT(b_out), .FIFOA_empty(b_empty), .FIFOA_ren(b_ren),
        .FIFOB_full(b_full), .FIFOB_IN(b_in), .FIFOB_wen(b_wen), .enable(b_en), .mode(b_mode),
        .clr(b_clr), .busy(b_busy), .xfer_count(b_cnt),
`ifdef FIFO_BRIDGE_PARITY_EN
        .FIFOB_par(b_par), .par_err_cnt(b_perr),
`endif
        .Triggered(b_trig));

    // FIFO A models: data appears RD_LAT cycles after the ren cycle, filler otherwise
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [5:0]  wp_a = '0, rp_a = '0, wp_b = '0, rp_b = '0;
    logic [31:0] pa [4] = '{default: 32'hDEADBEEF};
    logic [31:0] pb [4] = '{default: 32'hDEADBEEF};

    always @(posedge CLK) begin
        pa[0] <= a_ren ? mem_a[rp_a] : 32'hDEADBEEF;
        pb[0] <= b_ren ? mem_b[rp_b] : 32'hDEADBEEF;
        for (int i = 1; i < 4; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
        if (a_ren) rp_a <= rp_a + 6'd1;
        if (b_ren) rp_b <= rp_b + 6'd1;
    end

    assign a_out   = pa[0];
    assign b_out   = pb[2];
    assign a_empty = (rp_a == wp_a);
    assign b_empty = (rp_b == wp_b);

    task automatic push(input bit b, input logic [31:0] w);
        if (b) begin mem_b[wp_b] = w; wp_b = wp_b + 6'd1; end
        else   begin mem_a[wp_a] = w; wp_a = wp_a + 6'd1; end
    endtask

    task automatic watch(input bit b, input int cycles, output int t_ren, output int t_wen,
                         output int n_ren, output int n_wen, output logic [31:0] wd);
        t_ren = -1; t_wen = -1; n_ren = 0; n_wen = 0; wd = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (b ? b_ren : a_ren) begin
                n_ren++;
                if (t_ren < 0) t_ren = i;
            end
            if (b ? b_wen : a_wen) begin
                n_wen++;
                if (t_wen < 0) begin t_wen = i; wd = b ? b_in : a_in; end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge CLK);
        n_tests++;
        if ({a_ren, a_wen, a_busy, a_trig, a_in, a_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_a: outputs=%h required 0", {a_ren, a_wen, a_busy, a_trig, a_in, a_cnt});
        end
        n_tests++;
        if ({b_ren, b_wen, b_busy, b_trig, b_in, b_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_b: outputs=%h required 0", {b_ren, b_wen, b_busy, b_trig, b_in, b_cnt});
        end
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_pass;
        int tr, tw, nr, nw;
        logic [31:0] wd;
        push(0, 32'h12345678);
        a_mode = 2'd0; a_en = 1'b1;
        watch(0, 10, tr, tw, nr, nw, wd);
        a_en = 1'b0;
        n_tests++;
        if (nr !== 1) begin n_fail++; $display("FAIL pass_ren_count: got %0d required 1", nr); end
        n_tests++;
        if (tw - tr !== 2) begin n_fail++; $display("FAIL pass_latency: got %0d required 2", tw - tr); end
        n_tests++;
        if (wd !== 32'h12345678) begin n_fail++; $display("FAIL pass_data: got %h required 12345678", wd); end
        n_tests++;
        if (nw !== 1) begin n_fail++; $display("FAIL pass_wen_count: got %0d required 1", nw); end
        n_tests++;
        if (a_cnt !== 4'd1 || a_trig !== 1'b1) begin
            n_fail++; $display("FAIL pass_count_trig: got cnt=%0d trig=%b required 1 1", a_cnt, a_trig);
        end
        n_tests++;
        if (a_busy !== 1'b0 || a_in !== 32'h0) begin
            n_fail++; $display("FAIL pass_idle: got busy=%b in=%h required 0 0", a_busy, a_in);
        end
    endtask

    task automatic test_transform;
        int tr, tw, nr, nw;
        logic [31:0] wd;
        b_en = 1'b1;
        b_mode = 2'd2; push(1, 32'h11223344);
        watch(1, 12, tr, tw, nr, nw, wd);
        n_tests++;
        if (tw - tr !== 4) begin n_fail++; $display("FAIL xf_latency: got %0d required 4", tw - tr); end
        n_tests++;
        if (wd !== 32'h44332211) begin n_fail++; $display("FAIL xf_byterev: got %h required 44332211", wd); end
        b_mode = 2'd1; push(1, 32'h0000FFFF);
        watch(1, 12, tr, tw, nr, nw, wd);
        n_tests++;
        if (wd !== 32'hFFFF0000) begin n_fail++; $display("FAIL xf_invert: got %h required ffff0000", wd); end
        b_mode = 2'd3; push(1, 32'hA5A50F0F);
        watch(1, 12, tr, tw, nr, nw, wd);
        n_tests++;
        if (wd !== 32'hA5A50F0F) begin n_fail++; $display("FAIL xf_reserved: got %h required a5a50f0f", wd); end
        n_tests++;
        if (b_cnt !== 16'd3) begin n_fail++; $display("FAIL xf_count: got %0d required 3", b_cnt); end
        b_en = 1'b0; b_mode = 2'd0;
    endtask

    task automatic test_backpressure;
        bit got = 0;
        int nw = 0;
        push(0, 32'hCAFEF00D);
        a_en = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (a_ren) got = 1;
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL bp_start: no ren within 20 cycles"); end
        a_full = 1'b1; a_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_tests++;
            if (a_wen !== 1'b0 || a_busy !== 1'b1) begin
                n_fail++; $display("FAIL bp_stall[%0d]: got wen=%b busy=%b required 0 1", k, a_wen, a_busy);
            end
        end
        n_tests++;
        if (a_in !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bp_hold: got %h required cafef00d", a_in); end
        a_full = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (a_wen !== 1'b1 || a_in !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL bp_release: got wen=%b in=%h required 1 cafef00d", a_wen, a_in);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (a_wen) nw++;
        end
        n_tests++;
        if (nw !== 0 || a_cnt !== 4'd2) begin
            n_fail++; $display("FAIL bp_single: got extra=%0d cnt=%0d required 0 2", nw, a_cnt);
        end
    endtask

    task automatic test_enable_drop;
        int nr = 0, nw = 0;
        int tren [3];
        logic [31:0] last = '0;
        logic [15:0] c0;
        wp_b = rp_b;
        c0 = b_cnt;
        for (int i = 0; i < 10; i++) push(1, 32'h10000000 + 32'(i));
        b_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (b_ren) begin
                if (nr < 3) tren[nr] = i;
                nr++;
                if (nr == 3) b_en = 1'b0;
            end
            if (b_wen) begin nw++; last = b_in; end
        end
        n_tests++;
        if (nr !== 3 || nw !== 3) begin n_fail++; $display("FAIL en_drop_counts: got ren=%0d wen=%0d required 3 3", nr, nw); end
        n_tests++;
        if (last !== 32'h10000002) begin n_fail++; $display("FAIL en_drop_last: got %h required 10000002", last); end
        n_tests++;
        if (b_cnt !== c0 + 16'd3) begin n_fail++; $display("FAIL en_drop_cnt: got %0d required %0d", b_cnt, c0 + 16'd3); end
        n_tests++;
        if (tren[1] - tren[0] !== 6) begin n_fail++; $display("FAIL en_drop_spacing: got %0d required 6", tren[1] - tren[0]); end
        wp_b = rp_b;
    endtask

    task automatic test_saturate;
        int nw = 0;
        bit got = 0;
        a_clr = 1'b1; @(negedge CLK); a_clr = 1'b0;
        n_tests++;
        if (a_cnt !== 4'd0 || a_trig !== 1'b0) begin n_fail++; $display("FAIL clr_idle: got cnt=%0d trig=%b required 0 0", a_cnt, a_trig); end
        for (int i = 0; i < 17; i++) push(0, 32'h00000100 + 32'(i));
        a_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (a_wen) nw++;
        end
        a_en = 1'b0;
        n_tests++;
        if (nw !== 17) begin n_fail++; $display("FAIL sat_writes: got %0d required 17", nw); end
        n_tests++;
        if (a_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d required 15", a_cnt); end
        // clr during the wen cycle
        push(0, 32'h0000AAAA); a_en = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (a_wen) got = 1;
        end
        a_en = 1'b0; a_clr = 1'b1;
        @(negedge CLK); a_clr = 1'b0;
        n_tests++;
        if (!got || a_cnt !== 4'd0 || a_trig !== 1'b0) begin
            n_fail++; $display("FAIL clr_wen: got seen=%b cnt=%0d trig=%b required 1 0 0", got, a_cnt, a_trig);
        end
        // clr at the edge that arms the write
        got = 0;
        push(0, 32'h0000BBBB); a_en = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (a_ren) got = 1;
        end
        a_en = 1'b0;
        @(negedge CLK); a_clr = 1'b1;
        @(negedge CLK); a_clr = 1'b0;
        n_tests++;
        if (a_wen !== 1'b1 || a_cnt !== 4'd0 || a_trig !== 1'b0) begin
            n_fail++; $display("FAIL clr_arm: got wen=%b cnt=%0d trig=%b required 1 0 0", a_wen, a_cnt, a_trig);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        int tr, tw, nr, nw;
        logic [31:0] wd;
        bit got = 0;
        wp_b = rp_b;
        push(1, 32'h0BADC0DE); push(1, 32'h600DF00D);
        b_en = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (b_ren) got = 1;
        end
        @(negedge CLK);
        n_tests++;
        if (!got || b_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got seen=%b busy=%b required 1 1", got, b_busy); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({b_ren, b_wen, b_busy, b_trig, b_in, b_cnt} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h required 0", {b_ren, b_wen, b_busy, b_trig, b_in, b_cnt});
        end
        @(negedge CLK);
        rst_n = 1'b1;
        watch(1, 12, tr, tw, nr, nw, wd);
        n_tests++;
        if (nr !== 1 || nw !== 1 || wd !== 32'h600DF00D) begin
            n_fail++; $display("FAIL rst_mid_resume: got ren=%0d wen=%0d data=%h required 1 1 600df00d", nr, nw, wd);
        end
        n_tests++;
        if (b_cnt !== 16'd1 || b_trig !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_count: got cnt=%0d trig=%b required 1 1", b_cnt, b_trig);
        end
        b_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_transform();
        test_backpressure();
        test_enable_drop();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
